// File: rtl/dcache_line.sv
// One direct-mapped way of the L1 data cache: tag/valid/dirty plus 8-word lines.
// `define DCACHE_LINE_FILL_MERGE_EN to merge store bytes into a fill (one-cycle write-allocate).
module dcache_line #(
    parameter int INDEX_BITS = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           compare,
    input  logic           read,
    input  logic [31:0]    address_in,
    input  logic [3:0]     byte_w_en,
    input  logic [31:0]    data_in,
    input  logic [255:0]   data_line_in,
    output logic           hit,
    output logic           dirty,
    output logic           valid,
    output logic [31:0]    data_out,
    output logic [31:0]    address_out,
    output logic [255:0]   data_line_out
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 27 - INDEX_BITS;

    logic [255:0]      data_q  [LINES];
    logic [TAG_W-1:0]  tag_q   [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag_in;
    logic [7:0]            woff;
    logic [255:0]          cur_line;

    logic [255:0]      line_d;
    logic [TAG_W-1:0]  tag_d;
    logic              valid_d;
    logic              dirty_d;
    logic              we;

    logic unused_byte_off;
    assign unused_byte_off = &{1'b0, address_in[1:0]};

    assign idx      = address_in[4+INDEX_BITS:5];
    assign tag_in   = address_in[31:5+INDEX_BITS];
    assign woff     = {address_in[4:2], 5'b0};
    assign cur_line = data_q[idx];

    assign hit           = enable & valid_q[idx] & (tag_q[idx] == tag_in);
    assign valid         = valid_q[idx];
    assign dirty         = dirty_q[idx];
    assign data_line_out = cur_line;
    assign data_out      = cur_line[woff +: 32];
    assign address_out   = {tag_q[idx], idx, 5'b0};

    // Byte-lane merge of data_in into the addressed word of a line.
    function automatic logic [255:0] merge_word(
        input logic [255:0] base,
        input logic [7:0]   off,
        input logic [3:0]   be,
        input logic [31:0]  wd
    );
        logic [255:0] r;
        r = base;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[off + 8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        line_d  = cur_line;
        tag_d   = tag_q[idx];
        valid_d = valid_q[idx];
        dirty_d = dirty_q[idx];
        we      = 1'b0;
        if (enable && !read) begin
            if (compare) begin
                if (hit) begin
                    line_d  = merge_word(cur_line, woff, byte_w_en, data_in);
                    dirty_d = dirty_q[idx] | (|byte_w_en);
                    we      = 1'b1;
                end
            end else begin
                line_d  = data_line_in;
                tag_d   = tag_in;
                valid_d = 1'b1;
                dirty_d = 1'b0;
                we      = 1'b1;
`ifdef DCACHE_LINE_FILL_MERGE_EN
                if (|byte_w_en) begin
                    line_d  = merge_word(data_line_in, woff, byte_w_en, data_in);
                    dirty_d = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (we) begin
            data_q[idx]  <= line_d;
            tag_q[idx]   <= tag_d;
            valid_q[idx] <= valid_d;
            dirty_q[idx] <= dirty_d;
        end
    end

endmodule

// File: tb/tb_dcache_line.sv
// Self-checking bench for dcache_line: vector table + expectation queue.
// Define DCACHE_LINE_FILL_MERGE_EN here too when testing the merge build.
module tb_dcache_line;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable, compare, read;
    logic [31:0]  address_in, data_in;
    logic [3:0]   byte_w_en;
    logic [255:0] data_line_in;
    logic         hit, dirty, valid;
    logic [31:0]  data_out, address_out;
    logic [255:0] data_line_out;

    dcache_line dut (
        .clk(clk), .rst(rst), .enable(enable), .compare(compare),
        .read(read), .address_in(address_in), .byte_w_en(byte_w_en),
        .data_in(data_in), .data_line_in(data_line_in), .hit(hit),
        .dirty(dirty), .valid(valid), .data_out(data_out),
        .address_out(address_out), .data_line_out(data_line_out)
    );

    always #5 clk = ~clk;

`ifdef DCACHE_LINE_FILL_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    typedef struct {
        logic        en, cmp, rd;
        logic [31:0] addr;
        logic [3:0]  bwe;
        logic [31:0] din;
        logic        e_hit, e_valid, e_dirty;
        logic [31:0] e_dout, e_aout, e_w2;
    } vec_t;

    typedef struct {
        int          id;
        logic        hit, valid, dirty;
        logic [31:0] dout, aout, w2;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        logic en, logic cmp, logic rd, logic [31:0] addr, logic [3:0] bwe,
        logic [31:0] din, logic h, logic v, logic d,
        logic [31:0] dout, logic [31:0] aout, logic [31:0] w2
    );
        vec_t r;
        r.en = en; r.cmp = cmp; r.rd = rd; r.addr = addr; r.bwe = bwe;
        r.din = din; r.e_hit = h; r.e_valid = v; r.e_dirty = d;
        r.e_dout = dout; r.e_aout = aout; r.e_w2 = w2;
        return r;
    endfunction

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", nm, id, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        enable = v.en; compare = v.cmp; read = v.rd;
        address_in = v.addr; byte_w_en = v.bwe; data_in = v.din;
    endtask

    task automatic push_exp(input int id, input logic h, input logic v,
                            input logic d, input logic [31:0] dout,
                            input logic [31:0] aout, input logic [31:0] w2);
        exp_t e;
        e.id = id; e.hit = h; e.valid = v; e.dirty = d;
        e.dout = dout; e.aout = aout; e.w2 = w2;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got 0 entries want 1");
            return;
        end
        checks--;
        e = sb.pop_front();
        chk("hit",       e.id, {31'b0, hit},          {31'b0, e.hit});
        chk("valid",     e.id, {31'b0, valid},        {31'b0, e.valid});
        chk("dirty",     e.id, {31'b0, dirty},        {31'b0, e.dirty});
        chk("data_out",  e.id, data_out,              e.dout);
        chk("addr_out",  e.id, address_out,           e.aout);
        chk("line_word2", e.id, data_line_out[95:64], e.w2);
    endtask

    logic [255:0] fill_line;

    initial begin
        for (int k = 0; k < 8; k++) fill_line[32*k +: 32] = 32'h1000_0000 + k;

        // mk(en,cmp,rd,addr,bwe,din, hit,valid,dirty,dout,aout,word2)
        vecs.push_back(mk(1,1,1,32'h0000_0040,4'h0,32'h0,
                          0,0,0,32'h0,32'h0000_0040,32'h0));
        vecs.push_back(mk(1,0,0,32'h1234_5660,4'h0,32'h0,
                          0,0,0,32'h0,32'h0000_0260,32'h0));
        vecs.push_back(mk(1,1,1,32'h1234_5668,4'h0,32'h0,
                          1,1,0,32'h1000_0002,32'h1234_5660,32'h1000_0002));
        vecs.push_back(mk(1,1,0,32'h1234_5668,4'b0011,32'hAABB_CCDD,
                          1,1,0,32'h1000_0002,32'h1234_5660,32'h1000_0002));
        vecs.push_back(mk(1,1,1,32'h1234_5668,4'h0,32'h0,
                          1,1,1,32'h1000_CCDD,32'h1234_5660,32'h1000_CCDD));
        vecs.push_back(mk(1,1,0,32'h9234_5668,4'hF,32'hFFFF_FFFF,
                          0,1,1,32'h1000_CCDD,32'h1234_5660,32'h1000_CCDD));
        vecs.push_back(mk(1,0,1,32'h9234_5660,4'h0,32'h0,
                          0,1,1,32'h1000_0000,32'h1234_5660,32'h1000_CCDD));
        vecs.push_back(mk(0,0,0,32'h1234_5668,4'hF,32'h1111_1111,
                          0,1,1,32'h1000_CCDD,32'h1234_5660,32'h1000_CCDD));
        vecs.push_back(mk(0,1,0,32'h1234_5668,4'hF,32'h0,
                          0,1,1,32'h1000_CCDD,32'h1234_5660,32'h1000_CCDD));
        vecs.push_back(mk(1,1,1,32'h1234_5668,4'h0,32'h0,
                          1,1,1,32'h1000_CCDD,32'h1234_5660,32'h1000_CCDD));
        vecs.push_back(mk(1,0,0,32'h0000_0080,4'h0,32'h0,
                          0,0,0,32'h0,32'h0000_0080,32'h0));
        vecs.push_back(mk(1,1,0,32'h0000_009C,4'h0,32'hFFFF_FFFF,
                          1,1,0,32'h1000_0007,32'h0000_0080,32'h1000_0002));
        vecs.push_back(mk(1,1,0,32'h0000_009C,4'b1000,32'h5A12_3456,
                          1,1,0,32'h1000_0007,32'h0000_0080,32'h1000_0002));
        vecs.push_back(mk(1,1,1,32'h0000_009C,4'h0,32'h0,
                          1,1,1,32'h5A00_0007,32'h0000_0080,32'h1000_0002));
        vecs.push_back(mk(1,1,1,32'h0000_0000,4'h0,32'h0,
                          0,0,0,32'h0,32'h0000_0000,32'h0));
        vecs.push_back(mk(1,0,0,32'hABCD_E660,4'h0,32'h0,
                          0,1,1,32'h1000_0000,32'h1234_5660,32'h1000_CCDD));
        vecs.push_back(mk(1,1,1,32'hABCD_E668,4'h0,32'h0,
                          1,1,0,32'h1000_0002,32'hABCD_E660,32'h1000_0002));
        vecs.push_back(mk(1,0,0,32'h0000_0104,4'hF,32'hDEAD_BEEF,
                          0,0,0,32'h0,32'h0000_0100,32'h0));
        vecs.push_back(mk(1,1,1,32'h0000_0104,4'h0,32'h0,
                          1,1,MERGE,MERGE ? 32'hDEAD_BEEF : 32'h1000_0001,
                          32'h0000_0100,32'h1000_0002));

        rst = 1'b1;
        data_line_in = fill_line;
        drive(mk(0,1,1,32'h0,4'h0,32'h0,0,0,0,0,0,0));
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            push_exp(i, vecs[i].e_hit, vecs[i].e_valid, vecs[i].e_dirty,
                     vecs[i].e_dout, vecs[i].e_aout, vecs[i].e_w2);
            #1 pop_check();
        end

        // Reset asserted between clock edges takes effect immediately.
        @(negedge clk);
        drive(mk(1,1,1,32'hABCD_E668,4'h0,32'h0,0,0,0,0,0,0));
        push_exp(100, 1, 1, 0, 32'h1000_0002, 32'hABCD_E660, 32'h1000_0002);
        #1 pop_check();
        #1 rst = 1'b0;
        push_exp(101, 0, 0, 0, 32'h0, 32'h0000_0260, 32'h0);
        #1 pop_check();

        // Fill held in reset across a rising edge must not land.
        drive(mk(1,0,0,32'hABCD_E660,4'h0,32'h0,0,0,0,0,0,0));
        @(posedge clk);
        @(negedge clk);
        push_exp(102, 0, 0, 0, 32'h0, 32'h0000_0260, 32'h0);
        #1 pop_check();
        rst = 1'b1;
        drive(mk(1,1,1,32'hABCD_E668,4'h0,32'h0,0,0,0,0,0,0));
        push_exp(103, 0, 0, 0, 32'h0, 32'h0000_0260, 32'h0);
        #1 pop_check();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
